// File: rtl/fxp_pkg.sv
// Shared constants, saturation helpers and the default stage payload layout
// for the pipelined fixed-point variable shifter.
package fxp_pkg;

  localparam int FXP_WIDTH   = 64;
  localparam int FXP_FRAC    = 48;
  localparam int FXP_SHAMT_W = 64;
  localparam int FXP_TAG_W   = 4;

  localparam logic DIR_LS = 1'b0;
  localparam logic DIR_RS = 1'b1;

  // Largest / most negative w-bit two's-complement values, zero-extended to 128 bits.
  function automatic logic [127:0] fxp_max(input int w);
    return (128'd1 << (w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] fxp_min(input int w);
    return 128'd1 << (w - 1);
  endfunction

  // Stage payload for the default configuration; the top re-declares it with its own widths.
  typedef struct packed {
    logic [FXP_WIDTH-1:0]         data;
    logic [$clog2(FXP_WIDTH)-1:0] shamt;
    logic                         dir;
    logic                         round;
    logic                         ovf;
    logic [FXP_TAG_W-1:0]         tag;
  } fxp_stage_t;

endpackage

// File: rtl/fxp_pipe_reg.sv
// One valid/ready pipeline register; accepts a new item whenever it is empty
// or its current item is leaving, so bubbles collapse.
module fxp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready_o  = ~valid_q | out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/fxp_var_shifter_pipe.sv
// Three-stage saturating / rounding arithmetic shifter for signed fixed-point
// words with valid/ready flow control, tag pass-through and a sticky overflow flag.
module fxp_var_shifter_pipe
  import fxp_pkg::*;
#(
  parameter int WIDTH   = FXP_WIDTH,
  parameter int FRAC    = FXP_FRAC,
  parameter int SHAMT_W = FXP_SHAMT_W,
  parameter int TAG_W   = FXP_TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shift,
  input  logic               in_dir,
  input  logic               in_round,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_ovf,
  output logic               ovf_sticky,
  input  logic               clr_sticky
);

  localparam int LOG_W = $clog2(WIDTH);
  localparam int SX    = (SHAMT_W > LOG_W) ? SHAMT_W : LOG_W + 1;

  if ((1 << LOG_W) != WIDTH || WIDTH < 8 || WIDTH > 128) begin : g_bad_width
    $error("WIDTH must be a power of two in 8..128");
  end
  if (FRAC < 0 || FRAC > WIDTH) begin : g_bad_frac
    $error("FRAC must lie in 0..WIDTH");
  end

  // After S1, 'round' holds the +1 increment and 'shamt' is already clamped.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [LOG_W-1:0] shamt;
    logic             dir;
    logic             round;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } stage_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } result_t;

  localparam int PW = $bits(stage_t);
  localparam int RW = $bits(result_t);

  stage_t  s1_d, s1_q, s2_d, s2_q;
  result_t s3_d, s3_q;
  logic    s1_valid, s2_valid, s2_ready, s3_ready;

  // ---------------- S1: decode ----------------
  logic [SX-1:0]    s_ext;
  logic             big;
  logic [LOG_W-1:0] sh;
  logic [LOG_W:0]   sh_p1;
  logic             sign;
  logic [WIDTH-1:0] top_mask;
  logic             ls_ovf;
  logic             rnd_bit;

  assign s_ext    = SX'(in_shift);
  assign big      = |s_ext[SX-1:LOG_W];
  assign sh       = s_ext[LOG_W-1:0];
  assign sh_p1    = {1'b0, sh} + (LOG_W + 1)'(1);
  assign sign     = in_data[WIDTH-1];
  // Covers bits [WIDTH-1 : WIDTH-1-s]; all of them must match the sign for x << s to fit.
  assign top_mask = ~({WIDTH{1'b1}} >> sh_p1);
  assign ls_ovf   = big ? (in_data != '0)
                        : (((in_data ^ {WIDTH{sign}}) & top_mask) != '0);
  // Round-half-up equals floor(x / 2^s) plus the last bit shifted out.
  assign rnd_bit  = (sh != '0) && in_data[sh - LOG_W'(1)];

  always_comb begin
    s1_d       = '0;
    s1_d.data  = in_data;
    s1_d.shamt = sh;
    s1_d.dir   = in_dir;
    s1_d.tag   = in_tag;
    if (in_dir == DIR_LS) begin
      s1_d.ovf = ls_ovf;
      // Saturating items travel unshifted so S3 still sees the original sign.
      if (ls_ovf || big) s1_d.shamt = '0;
    end else begin
      s1_d.round = in_round & rnd_bit & ~big;
      if (big) begin
        s1_d.shamt = '0;
        s1_d.data  = in_round ? '0 : {WIDTH{sign}};
      end
    end
  end

  fxp_pipe_reg #(.W(PW)) u_s1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (s1_d),
    .out_valid_o(s1_valid),
    .out_ready_i(s2_ready),
    .out_data_o (s1_q)
  );

  // ---------------- S2: shift by s[2:0] ----------------
  always_comb begin
    s2_d = s1_q;
    if (s1_q.dir == DIR_LS) s2_d.data = s1_q.data << s1_q.shamt[2:0];
    else                    s2_d.data = $signed(s1_q.data) >>> s1_q.shamt[2:0];
  end

  fxp_pipe_reg #(.W(PW)) u_s2 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (s1_valid),
    .in_ready_o (s2_ready),
    .in_data_i  (s2_d),
    .out_valid_o(s2_valid),
    .out_ready_i(s3_ready),
    .out_data_o (s2_q)
  );

  // ---------------- S3: shift by remaining bits, saturate / round ----------------
  logic [LOG_W-1:0] sh_hi;
  logic [WIDTH-1:0] shifted;

  assign sh_hi = s2_q.shamt & ~LOG_W'(7);

  always_comb begin
    shifted  = '0;
    s3_d     = '0;
    s3_d.tag = s2_q.tag;
    s3_d.ovf = s2_q.ovf;
    if (s2_q.dir == DIR_LS) shifted = s2_q.data << sh_hi;
    else                    shifted = $signed(s2_q.data) >>> sh_hi;
    if (s2_q.ovf) s3_d.data = s2_q.data[WIDTH-1] ? WIDTH'(fxp_min(WIDTH)) : WIDTH'(fxp_max(WIDTH));
    else          s3_d.data = shifted + WIDTH'(s2_q.round);
  end

  fxp_pipe_reg #(.W(RW)) u_s3 (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (s2_valid),
    .in_ready_o (s3_ready),
    .in_data_i  (s3_d),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s3_q)
  );

  assign out_data = s3_q.data;
  assign out_tag  = s3_q.tag;
  assign out_ovf  = s3_q.ovf;

  // A set in the same cycle as a clear wins so no overflow event is lost.
  logic sticky_q, sticky_d;
  assign sticky_d   = (out_valid & out_ready & out_ovf) | (sticky_q & ~clr_sticky);
  assign ovf_sticky = sticky_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_fxp_var_shifter_pipe.sv
// Randomised and directed bench for fxp_var_shifter_pipe against an arithmetic
// reference model; one line per mismatch and a final summary line.
module tb_fxp_var_shifter_pipe;

  localparam int W  = 64;
  localparam int SW = 64;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_dir, in_round;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shift;
  logic [TW-1:0] in_tag;
  logic          out_valid, out_ready, out_ovf, ovf_sticky, clr_sticky;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  fxp_var_shifter_pipe #(.WIDTH(W), .FRAC(48), .SHAMT_W(SW), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .in_round  (in_round),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .out_ovf   (out_ovf),
    .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          ovf;
    int            in_cyc;
  } exp_t;
  exp_t expq[$];

  bit   tp_phase   = 0;
  bit   rand_ready = 0;
  logic ready_val  = 1'b1;

  // Reference: exact integer arithmetic on 128-bit values.
  function automatic void model(input logic [63:0] x, input logic [63:0] s, input logic dir,
                                input logic rnd, output logic [63:0] r, output logic ov);
    logic signed [127:0] xs, full, hi, lo;
    xs   = {{64{x[63]}}, x};
    hi   = 128'sh7FFF_FFFF_FFFF_FFFF;
    lo   = -128'sh8000_0000_0000_0000;
    full = '0;
    ov   = 1'b0;
    if (!dir) begin
      if (s >= 64) ov = (x != 0);
      else begin
        full = xs <<< s;
        ov   = (full > hi) || (full < lo);
      end
      r = ov ? (x[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF) : full[63:0];
    end else if (s >= 64) begin
      r = (rnd || !x[63]) ? 64'd0 : '1;
    end else if (!rnd || s == 0) begin
      full = xs >>> s;
      r    = full[63:0];
    end else begin
      full = (xs + (128'sd1 <<< (s - 1))) >>> s;
      r    = full[63:0];
    end
  endfunction

  task automatic send(input logic [63:0] x, input logic [63:0] s, input logic dir,
                      input logic rnd, input logic [3:0] tag,
                      input bit use_fixed, input logic [63:0] fx, input logic fo);
    exp_t e;
    bit   done = 0;
    in_valid = 1'b1; in_data = x; in_shift = s; in_dir = dir; in_round = rnd; in_tag = tag;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(x, s, dir, rnd, e.data, e.ovf);
        if (use_fixed) begin e.data = fx; e.ovf = fo; end
        e.tag    = tag;
        e.in_cyc = cyc + 1;
        expq.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && expq.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", 128'(expq.size()), 128'(0));
  endtask

  task automatic rand_item(output logic [63:0] x, output logic [63:0] s);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       x = {$urandom, $urandom};
      1:       x = {{32{r[31]}}, r};
      default: x = {{61{r[31]}}, r[2:0]};
    endcase
    case ($urandom_range(0, 3))
      0:       s = 64'($urandom_range(0, 63));
      1:       s = 64'($urandom_range(0, 7));
      2:       s = 64'($urandom_range(64, 70));
      default: s = {$urandom, $urandom};
    endcase
  endtask

  // out_ready driver: random or forced, updated shortly after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Output monitor: scoreboard compare on transfer, stability check while stalled.
  initial begin
    logic [W-1:0]  hd;
    logic [TW-1:0] ht;
    logic          ho;
    bit            stalled;
    exp_t          e;
    stalled = 0;
    forever begin
      @(negedge clk);
      if (rst) begin stalled = 0; continue; end
      if (stalled) begin
        check("stall_valid", 128'(out_valid), 128'(1));
        check("stall_data", 128'({out_tag, out_ovf, out_data}), 128'({ht, ho, hd}));
      end
      stalled = 0;
      if (out_valid && !out_ready) begin
        stalled = 1; hd = out_data; ht = out_tag; ho = out_ovf;
      end else if (out_valid && out_ready) begin
        if (expq.size() == 0) check("spurious_out", 128'(out_valid), 128'(0));
        else begin
          e = expq.pop_front();
          check("data", 128'(out_data), 128'(e.data));
          check("ovf", 128'(out_ovf), 128'(e.ovf));
          check("tag", 128'(out_tag), 128'(e.tag));
          // Result is visible two edges after the transfer edge (three pipeline cycles).
          if (tp_phase) check("latency", 128'(cyc - e.in_cyc), 128'(2));
        end
      end
    end
  end

  typedef struct {
    logic [63:0] x;
    logic [63:0] s;
    logic        dir;
    logic        rnd;
    logic [63:0] r;
    logic        ov;
  } vec_t;

  initial begin
    vec_t        dv[$];
    logic [63:0] x, s;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
    in_round = 1'b0; in_tag = '0; clr_sticky = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", 128'(out_data), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    check("rst_out_ovf", 128'(out_ovf), 128'(0));
    check("rst_sticky", 128'(ovf_sticky), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));

    // Directed corner cases with hand-derived results.
    dv.push_back('{64'h0000_4000_0000_0000, 64'd17, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1});
    dv.push_back('{64'h0000_4000_0000_0000, 64'd16, 1'b0, 1'b0, 64'h4000_0000_0000_0000, 1'b0});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd63, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFE, 64'd63, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFB, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFB, 64'd1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
    dv.push_back('{64'd5, 64'd1, 1'b1, 1'b1, 64'd3, 1'b0});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd200, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0});
    dv.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd200, 1'b1, 1'b1, 64'd0, 1'b0});
    dv.push_back('{64'h1234_5678_9ABC_DEF0, 64'd64, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1});
    dv.push_back('{64'd0, 64'd500, 1'b0, 1'b0, 64'd0, 1'b0});
    dv.push_back('{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1});
    dv.push_back('{64'hDEAD_BEEF_1234_5678, 64'd0, 1'b0, 1'b0, 64'hDEAD_BEEF_1234_5678, 1'b0});
    dv.push_back('{64'hDEAD_BEEF_1234_5678, 64'd0, 1'b1, 1'b0, 64'hDEAD_BEEF_1234_5678, 1'b0});
    dv.push_back('{64'hDEAD_BEEF_1234_5678, 64'd0, 1'b1, 1'b1, 64'hDEAD_BEEF_1234_5678, 1'b0});
    foreach (dv[i]) send(dv[i].x, dv[i].s, dv[i].dir, dv[i].rnd, 4'(i), 1, dv[i].r, dv[i].ov);
    drain();

    // Back-to-back stream with out_ready held high.
    tp_phase = 1;
    for (int i = 0; i < 16; i++) begin
      rand_item(x, s);
      send(x, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 0, '0, 1'b0);
    end
    drain();
    tp_phase = 0;

    // Random stimulus with random gaps and random back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 400; i++) begin
      rand_item(x, s);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(x, s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i), 0, '0, 1'b0);
    end
    drain();
    rand_ready = 0;
    ready_val  = 1'b1;
    @(posedge clk); #1;

    // Sticky flag: clear alone, then set and clear in the same cycle.
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_clr", 128'(ovf_sticky), 128'(0));
    ready_val = 1'b0;
    @(posedge clk); #1;
    send(64'h7000_0000_0000_0000, 64'd5, 1'b0, 1'b0, 4'hA, 0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("sticky_stall_valid", 128'(out_valid), 128'(1));
    check("sticky_not_yet", 128'(ovf_sticky), 128'(0));
    ready_val  = 1'b1;
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_set_wins", 128'(ovf_sticky), 128'(1));
    clr_sticky = 1'b1;
    @(posedge clk); #1;
    clr_sticky = 1'b0;
    check("sticky_clr2", 128'(ovf_sticky), 128'(0));
    drain();

    // Reset with three items in flight, sticky set beforehand.
    send(64'h8000_0000_0000_0001, 64'd3, 1'b0, 1'b0, 4'h3, 0, '0, 1'b0);
    drain();
    @(posedge clk); #1;
    check("sticky_before_rst", 128'(ovf_sticky), 128'(1));
    ready_val = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      rand_item(x, s);
      send(x, s, 1'b0, 1'b0, 4'(i + 8), 0, '0, 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_sticky", 128'(ovf_sticky), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    expq.delete();
    @(posedge clk); #1;
    rst       = 1'b0;
    ready_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("post_rst_empty", 128'(out_valid), 128'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
